// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the legality / lane-extraction helpers used by the top and the aligner.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // True when the size/sign code is defined for the op and the address
    // is naturally aligned for that size.
    function automatic logic access_legal(input logic       store,
                                          input logic [2:0] f3,
                                          input logic [1:0] lane);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~lane[0];
            F3_W:    ok = (lane == 2'b00);
            F3_BU:   ok = ~store;
            F3_HU:   ok = ~store & ~lane[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] lane_extend(input logic [31:0] rdata,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [31:0] s;
        logic [31:0] r;
        s = rdata >> {lane, 3'b000};
        case (f3)
            F3_B:    r = {{24{s[7]}}, s[7:0]};
            F3_H:    r = {{16{s[15]}}, s[15:0]};
            F3_BU:   r = {24'h0, s[7:0]};
            F3_HU:   r = {16'h0, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and replicated write data for the
// outgoing request, and extraction/extension of the returned read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_lane,
    input  logic [31:0] req_data,
    input  logic [2:0]  rsp_funct3,
    input  logic [1:0]  rsp_lane,
    input  logic [31:0] rsp_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_ext
);

    always_comb begin
        be    = 4'b0000;
        wdata = req_data;
        case (req_funct3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << req_lane;
                wdata = {4{req_data[7:0]}};
            end
            F3_H, F3_HU: begin
                be    = 4'b0011 << req_lane;
                wdata = {2{req_data[15:0]}};
            end
            F3_W: be = 4'b1111;
            default: ;
        endcase
    end

    assign load_ext = lane_extend(rsp_rdata, rsp_lane, rsp_funct3);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one decoded load or store into a word-aligned memory
// request, waits for the ack (with timeout) and returns extended load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT);

    lsu_state_e       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
    logic             op_load, op_load_d;
    logic [2:0]       op_f3, op_f3_d;
    logic [1:0]       op_lane, op_lane_d;

    logic             done_d, fault_d, mem_req_d, mem_we_d;
    logic [31:0]      load_data_d, mem_addr_d, mem_wdata_d;
    logic [3:0]       mem_be_d;
    logic             stall_c;

    logic [3:0]       al_be;
    logic [31:0]      al_wdata, al_ext;

    lsu_align u_align (
        .req_funct3 (funct3),
        .req_lane   (addr[1:0]),
        .req_data   (store_data),
        .rsp_funct3 (op_f3),
        .rsp_lane   (op_lane),
        .rsp_rdata  (mem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_ext   (al_ext)
    );

    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        op_load_d   = op_load;
        op_f3_d     = op_f3;
        op_lane_d   = op_lane;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        load_data_d = load_data;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_be_d    = mem_be;
        mem_wdata_d = mem_wdata;
        stall_c     = 1'b0;

        case (state)
            ST_IDLE: begin
                mem_req_d = 1'b0;
                if (is_load | is_store) begin
                    if ((is_load ^ is_store) && access_legal(is_store, funct3, addr[1:0])) begin
                        stall_c     = 1'b1;
                        op_load_d   = is_load;
                        op_f3_d     = funct3;
                        op_lane_d   = addr[1:0];
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
                        cnt_d       = '0;
                        state_d     = ST_WAIT;
                    end else begin
                        fault_d     = 1'b1;
                        load_data_d = 32'h0;
                    end
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                // An ack on the timeout cycle still wins over the abort.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (op_load)
                        load_data_d = al_ext;
                    state_d = ST_RESP;
                end else if (cnt_inc == CNT_LAST) begin
                    mem_req_d   = 1'b0;
                    fault_d     = 1'b1;
                    load_data_d = 32'h0;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Reset forces stall low immediately, even mid-access.
    assign stall = stall_c & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_load   <= 1'b0;
            op_f3     <= 3'b000;
            op_lane   <= 2'b00;
            done      <= 1'b0;
            fault     <= 1'b0;
            load_data <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            op_load   <= op_load_d;
            op_f3     <= op_f3_d;
            op_lane   <= op_lane_d;
            done      <= done_d;
            fault     <= fault_d;
            load_data <= load_data_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_be    <= mem_be_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases followed by
// random loads/stores checked against an arithmetic reference model.
module tb_load_store_unit;

    localparam int ACK_TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, done, fault;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .done       (done),
        .load_data  (load_data),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit m_legal(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] a);
        int sz;
        sz = m_size(f3);
        if (ld == st) return 0;
        if (sz == 0) return 0;
        if (st && f3[2]) return 0;
        return (a % sz) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz, mask;
        sz   = m_size(f3);
        mask = ((1 << sz) - 1) << (a % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz;
        sz = m_size(f3);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] r);
        int     sz;
        longint v, span;
        sz = m_size(f3);
        if (sz == 4) return r;
        span = longint'(1) << (8 * sz);
        v    = (longint'(r) >> (8 * (a % 4))) % span;
        if (!f3[2] && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // ack_delay: cycle offset after accept at which mem_ack is raised (0 = never)
    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input int ack_delay, input logic [31:0] rdata);
        bit legal;
        legal = m_legal(ld, st, f3, a);
        @(negedge clk);
        is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = d;
        #1;
        chk("stall_accept", stall, legal);
        @(posedge clk); #1;
        is_load = 0; is_store = 0;
        if (!legal) begin
            chk("illegal_fault", fault, 1);
            chk("illegal_noreq", mem_req, 0);
            chk("illegal_stall", stall, 0);
            chk("illegal_ldata", load_data, 0);
            @(posedge clk); #1;
            chk("fault_pulse", fault, 0);
            return;
        end
        chk("req_up",  mem_req, 1);
        chk("req_we",  mem_we, st);
        chk("req_addr", mem_addr, {a[31:2], 2'b00});
        chk("req_be",  mem_be, m_be(f3, a));
        if (st) chk("req_wdata", mem_wdata, m_wdata(f3, d));
        for (int k = 1; k <= ACK_TIMEOUT; k++) begin
            if (k > 1) chk("wait_stall", stall, 1);
            if (k == ack_delay) begin
                mem_ack = 1; mem_rdata = rdata;
            end else begin
                mem_rdata = $urandom;
            end
            @(posedge clk); #1;
            mem_ack = 0;
            if (k == ack_delay) begin
                chk("done_up",  done, 1);
                chk("done_nofault", fault, 0);
                chk("done_req_drop", mem_req, 0);
                chk("done_stall", stall, 0);
                if (ld) chk("load_data", load_data, m_load(f3, a, rdata));
                @(posedge clk); #1;
                chk("done_pulse", done, 0);
                return;
            end
        end
        chk("tmo_fault", fault, 1);
        chk("tmo_nodone", done, 0);
        chk("tmo_req_drop", mem_req, 0);
        chk("tmo_ldata", load_data, 0);
        @(posedge clk); #1;
        chk("tmo_pulse", fault, 0);
    endtask

    initial begin
        rst = 0; is_load = 0; is_store = 0; funct3 = 0; addr = 0; store_data = 0;
        mem_rdata = 0; mem_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_ldata", load_data, 0);
        chk("rst_be", mem_be, 0);
        @(negedge clk); rst = 1;

        // directed cases
        do_op(1, 0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);          // LW
        do_op(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80112233);          // LB
        do_op(1, 0, 3'b100, 32'h103, 32'h0, 3, 32'h80112233);          // LBU
        do_op(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 1, 32'h0);          // SH
        do_op(1, 0, 3'b101, 32'h102, 32'h0, 1, 32'h8001_7FFF);         // HU upper half
        do_op(1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0);                 // misaligned LW
        do_op(1, 0, 3'b001, 32'h103, 32'h0, 1, 32'h0);                 // misaligned LH
        do_op(0, 1, 3'b100, 32'h100, 32'h0, 1, 32'h0);                 // store BU illegal
        do_op(1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0);                 // undefined funct3
        do_op(1, 1, 3'b010, 32'h100, 32'h0, 1, 32'h0);                 // load and store
        do_op(0, 1, 3'b010, 32'h300, 32'h12345678, 0, 32'h0);          // SW timeout
        do_op(1, 0, 3'b010, 32'h304, 32'h0, ACK_TIMEOUT, 32'hCAFEF00D); // ack on last cycle
        do_op(1, 0, 3'b000, 32'h0, 32'h0, 1, 32'h0000_007F);           // after timeout

        // idle ack is ignored
        @(negedge clk); mem_ack = 1; mem_rdata = 32'h5555_5555;
        @(posedge clk); #1; mem_ack = 0;
        chk("idle_ack_done", done, 0);
        chk("idle_ack_req", mem_req, 0);

        // reset in the middle of WAIT
        @(negedge clk);
        is_store = 1; funct3 = 3'b010; addr = 32'h400; store_data = 32'h1;
        @(posedge clk); #1; is_store = 0;
        repeat (3) @(posedge clk);
        #1; rst = 0; #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk); rst = 1;
        @(posedge clk); #1; mem_ack = 1; mem_rdata = 32'h7777_7777;
        @(posedge clk); #1; mem_ack = 0;
        chk("late_ack_done", done, 0);
        chk("late_ack_req", mem_req, 0);
        chk("late_ack_fault", fault, 0);
        do_op(1, 0, 3'b001, 32'h402, 32'h0, 2, 32'h8000_1234);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            bit          ld, st;
            logic [2:0]  f3;
            logic [31:0] a;
            int          dly, sel;
            sel = $urandom_range(0, 19);
            ld  = (sel < 10) || (sel == 19);
            st  = (sel >= 10);
            f3  = (sel < 17) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
            a   = $urandom;
            if ($urandom_range(0, 2) != 0)
                a = a & ~((m_size(f3) > 1) ? (m_size(f3) - 1) : 0);
            dly = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, 5);
            do_op(ld, st, f3, a, $urandom, dly, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
